nanci_sort_seq: RTL and testbench
=================================

NANCI_SORT_SEQ -- requirements
Module: nanci_sort_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 Parameter SQRT_N SHALL default to 4 and gives the mesh side length; legal values are 1 or more.
REQ-003 Parameter SORT_CYCLES SHALL default to 1 and gives the clock cycles per compare-exchange step; legal values are 1 or more.
REQ-004 Port clk SHALL be input, width 1: the system clock.
REQ-005 Port rst SHALL be input, width 1: asynchronous reset, active high.
REQ-006 Port i_start SHALL be input, width 1: a request to begin a sort.
REQ-007 Port i_stop SHALL be input, width 1: a synchronous abort.
REQ-008 Port o_busy SHALL be output, width 1: a sort is in progress.
REQ-009 Port o_row SHALL be output, width 1: 1 during a row phase, 0 during a column phase.
REQ-010 Port o_odd SHALL be output, width 1: odd-even transposition step parity.
REQ-011 Port o_step_en SHALL be output, width 1: the PE latch strobe.
REQ-012 Port o_done SHALL be output, width 1: a one-cycle completion pulse.
REQ-013 Port o_phase SHALL be output, width clog2(2R): the index of the current phase.

Function
REQ-014 The block SHALL sequence a shearsort over an SQRT_N x SQRT_N PE mesh.
REQ-015 R SHALL equal clog2(SQRT_N)+1.
REQ-016 The phase order SHALL be ROW, COL, ROW, COL, ... ROW: R row phases and R-1 column phases, 2R-1 phases in total.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE, i_start=1 SHALL move the FSM to RUN on the next edge, with phase 0, step 0 and cycle 0.
REQ-019 In RUN, each phase SHALL consist of SQRT_N steps, and each step of SORT_CYCLES cycles.
REQ-020 o_odd SHALL equal the step index modulo 2, restarting at 0 at the start of each phase.
REQ-021 o_step_en SHALL be 1 only in the last cycle of each step.
REQ-022 o_row SHALL be 1 when the phase index is even.
REQ-023 After the last cycle of the last step of phase 2R-2, RUN SHALL go to DONE.
REQ-024 DONE SHALL last one cycle with o_done=1 and o_busy=0, then go to IDLE.
REQ-025 o_busy SHALL be 1 exactly while in RUN, so the busy length is (2R-1)*SQRT_N*SORT_CYCLES cycles.
REQ-026 i_start SHALL be ignored in RUN and in DONE.
REQ-027 i_stop=1 in RUN SHALL move the FSM to IDLE on the next edge with no o_done pulse; o_step_en SHALL be 0 in that cycle even when it is a step's last cycle.
REQ-028 When i_start and i_stop are both 1 in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-029 i_stop SHALL be ignored in DONE.
REQ-030 The cycle, step and phase counters SHALL each wrap to 0 at terminal count; none SHALL ever exceed its terminal value.
REQ-031 When SQRT_N=1, the block SHALL produce one phase of one step: o_row=1, o_odd=0.
REQ-032 All outputs SHALL be registered, with no combinational path from input to output.
REQ-033 In IDLE, o_row, o_odd, o_step_en and o_phase SHALL be 0.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, all counters to 0 and every output to 0, regardless of the clock.
REQ-035 Asserting rst in the middle of a sort SHALL abandon it with no o_done pulse.
REQ-036 After rst deasserts, the block SHALL require a new i_start before it sorts again.

Structure
REQ-037 Shared package nanci_pkg SHALL hold the FSM state encoding (IDLE/RUN/DONE), the phase-type constants ROW=1/COL=0, and the clog2 helper.
REQ-038 One sub-module, nanci_step_timer, SHALL hold the SORT_CYCLES cycle counter and generate the end-of-step strobe.
REQ-039 The step and phase counters and the FSM SHALL stay in nanci_sort_seq.

Verification
REQ-040 Scenario, SQRT_N=4 and SORT_CYCLES=1: pulse i_start for 1 cycle -> o_busy=1 for 20 cycles, o_step_en=1 on every busy cycle, o_row sequence 1,0,1,0,1 (4 cycles each), o_odd 0,1,0,1 within each phase, o_done=1 for one cycle after the 20th.
REQ-041 Scenario, SQRT_N=4 and SORT_CYCLES=2: start -> busy for 40 cycles, o_step_en=1 on odd cycle offsets only (20 pulses), o_done after cycle 40.
REQ-042 Scenario: i_stop at busy cycle 7 -> IDLE on the next edge, no o_done, no o_step_en in the stop cycle; a following i_start produces a full 20-cycle run.
REQ-043 Scenario: i_start held high for the whole run and i_start+i_stop asserted together in IDLE -> no restart during RUN or DONE, and no start in the simultaneous case.
REQ-044 Scenario: async rst asserted mid-cycle at busy cycle 10 -> all outputs 0 before the next clk edge, no o_done pulse.
REQ-045 Scenario, SQRT_N=1: start -> o_busy=1 for 1 cycle with o_row=1, o_odd=0, o_step_en=1, then o_done=1.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared definitions for the shearsort sequencer: FSM encoding, phase types, clog2.
package nanci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Phase type as seen on o_row.
  localparam logic ROW = 1'b1;
  localparam logic COL = 1'b0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nanci_step_timer.sv
// Counts SORT_CYCLES cycles per compare-exchange step and produces the PE latch strobe.
module nanci_step_timer
  import nanci_pkg::*;
#(
  parameter int unsigned SORT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,      // sequencer is in RUN this cycle
  input  logic i_run_d,    // sequencer will be in RUN next cycle
  output logic o_end_c,    // this cycle is the last of the current step
  output logic o_step_en   // registered strobe, aligned with the sequencer outputs
);

  localparam int unsigned CW = (clog2(SORT_CYCLES) > 0) ? clog2(SORT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_MAX = CW'(SORT_CYCLES - 1);

  logic [CW-1:0] cyc_q, cyc_d;
  logic          step_en_q, step_en_d;

  // Next cycle count: restarts on entry to RUN, wraps at terminal count, parks at 0 otherwise.
  always_comb begin
    cyc_d = '0;
    if (i_run && i_run_d) begin
      cyc_d = (cyc_q == CYC_MAX) ? '0 : cyc_q + CW'(1);
    end
    step_en_d = i_run_d && (cyc_d == CYC_MAX);
  end

  // Cycle counter and strobe register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q     <= '0;
      step_en_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      step_en_q <= step_en_d;
    end
  end

  assign o_end_c   = i_run && (cyc_q == CYC_MAX);
  assign o_step_en = step_en_q;

endmodule

// File: rtl/nanci_sort_seq.sv
// Shearsort sequencer for an SQRT_N x SQRT_N PE mesh: alternating row/column
// odd-even transposition phases, SQRT_N steps per phase, 2R-1 phases.
// Outputs are registered from next-state values so they line up with the state register.
module nanci_sort_seq
  import nanci_pkg::*;
#(
  parameter  int unsigned SQRT_N      = 4,
  parameter  int unsigned SORT_CYCLES = 1,
  localparam int unsigned PW          = clog2(2 * (clog2(SQRT_N) + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_stop,
  output logic          o_busy,
  output logic          o_row,
  output logic          o_odd,
  output logic          o_step_en,
  output logic          o_done,
  output logic [PW-1:0] o_phase
);

  localparam int unsigned R    = clog2(SQRT_N) + 1;
  localparam int unsigned NPH  = 2 * R - 1;
  localparam int unsigned SW   = (clog2(SQRT_N) > 0) ? clog2(SQRT_N) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(SQRT_N - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'(NPH - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          end_c;
  logic          run_c, run_d;

  logic          busy_q, busy_d;
  logic          row_q, row_d;
  logic          odd_q, odd_d;
  logic          done_q, done_d;
  logic [PW-1:0] phase_out_q, phase_out_d;

  assign run_c = (state_q == RUN);
  assign run_d = (state_d == RUN);

  nanci_step_timer #(
    .SORT_CYCLES(SORT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_run    (run_c),
    .i_run_d  (run_d),
    .o_end_c  (end_c),
    .o_step_en(o_step_en)
  );

  // Next state, step/phase counters and registered-output values.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        step_d  = '0;
        phase_d = '0;
        if (i_start && !i_stop) state_d = RUN;
      end
      RUN: begin
        if (i_stop) begin
          state_d = IDLE;
          step_d  = '0;
          phase_d = '0;
        end else if (end_c) begin
          if (step_q == STEP_MAX) begin
            step_d = '0;
            if (phase_q == PH_MAX) begin
              phase_d = '0;
              state_d = DONE;
            end else begin
              phase_d = phase_q + PW'(1);
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        phase_d = '0;
      end
    endcase

    busy_d      = run_d;
    row_d       = run_d ? (phase_d[0] ? COL : ROW) : 1'b0;
    odd_d       = run_d && step_d[0];
    done_d      = (state_d == DONE);
    phase_out_d = run_d ? phase_d : '0;
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      row_q       <= 1'b0;
      odd_q       <= 1'b0;
      done_q      <= 1'b0;
      phase_out_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      row_q       <= row_d;
      odd_q       <= odd_d;
      done_q      <= done_d;
      phase_out_q <= phase_out_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_row   = row_q;
  assign o_odd   = odd_q;
  assign o_done  = done_q;
  assign o_phase = phase_out_q;

endmodule

// File: tb/tb_nanci_sort_seq.sv
// Directed bench for nanci_sort_seq: three instances (4x4/1 cycle, 4x4/2 cycles, 1x1).
module tb_nanci_sort_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: SQRT_N=4, SORT_CYCLES=1
  logic a_start = 1'b0, a_stop = 1'b0;
  logic a_busy, a_row, a_odd, a_sten, a_done;
  logic [2:0] a_phase;
  // Instance B: SQRT_N=4, SORT_CYCLES=2
  logic b_start = 1'b0, b_stop = 1'b0;
  logic b_busy, b_row, b_odd, b_sten, b_done;
  logic [2:0] b_phase;
  // Instance C: SQRT_N=1, SORT_CYCLES=1
  logic c_start = 1'b0, c_stop = 1'b0;
  logic c_busy, c_row, c_odd, c_sten, c_done;
  logic [0:0] c_phase;

  nanci_sort_seq #(.SQRT_N(4), .SORT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_stop(a_stop),
    .o_busy(a_busy), .o_row(a_row), .o_odd(a_odd), .o_step_en(a_sten),
    .o_done(a_done), .o_phase(a_phase));

  nanci_sort_seq #(.SQRT_N(4), .SORT_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_stop(b_stop),
    .o_busy(b_busy), .o_row(b_row), .o_odd(b_odd), .o_step_en(b_sten),
    .o_done(b_done), .o_phase(b_phase));

  nanci_sort_seq #(.SQRT_N(1), .SORT_CYCLES(1)) u_c (
    .clk(clk), .rst(rst), .i_start(c_start), .i_stop(c_stop),
    .o_busy(c_busy), .o_row(c_row), .o_odd(c_odd), .o_step_en(c_sten),
    .o_done(c_done), .o_phase(c_phase));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic busy, input logic row, input logic odd,
                       input logic sten, input logic done, input logic [2:0] ph);
    check({tag, ".busy"},  32'(a_busy),  32'(busy));
    check({tag, ".row"},   32'(a_row),   32'(row));
    check({tag, ".odd"},   32'(a_odd),   32'(odd));
    check({tag, ".sten"},  32'(a_sten),  32'(sten));
    check({tag, ".done"},  32'(a_done),  32'(done));
    check({tag, ".phase"}, 32'(a_phase), 32'(ph));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int n;

    // Reset state
    tick();
    tick();
    chk_a("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("rst.b_busy", 32'(b_busy), 32'd0);
    check("rst.c_busy", 32'(c_busy), 32'd0);
    rst = 1'b0;
    tick();
    chk_a("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Basic run, 4x4, one cycle per step
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk_a($sformatf("runA%0d", k), 1'b1, 1'((k / 4) % 2 == 0), 1'(k % 2), 1'b1, 1'b0, 3'(k / 4));
      tick();
    end
    chk_a("doneA", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    chk_a("postA", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Two cycles per step
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("runB%0d.busy", k),  32'(b_busy),  32'd1);
      check($sformatf("runB%0d.sten", k),  32'(b_sten),  32'(k % 2));
      check($sformatf("runB%0d.phase", k), 32'(b_phase), 32'(k / 8));
      check($sformatf("runB%0d.odd", k),   32'(b_odd),   32'((k / 2) % 2));
      check($sformatf("runB%0d.row", k),   32'(b_row),   32'((k / 8) % 2 == 0));
      if (b_sten) pulses++;
      tick();
    end
    check("B.pulses", 32'(pulses), 32'd20);
    check("B.done", 32'(b_done), 32'd1);
    check("B.busy_end", 32'(b_busy), 32'd0);
    tick();
    check("B.done_clr", 32'(b_done), 32'd0);

    // Stop at busy cycle 7, then a full restart
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("stop.pre_busy", 32'(a_busy), 32'd1);
    check("stop.pre_phase", 32'(a_phase), 32'd1);
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    chk_a("stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stop.no_done", 32'(a_done), 32'd0);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (a_busy && n < 100) begin
      n++;
      tick();
    end
    check("restart.len", 32'(n), 32'd20);
    check("restart.done", 32'(a_done), 32'd1);
    tick();

    // Start held through RUN and DONE must not restart the sort
    a_start = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("hold%0d.busy", k), 32'(a_busy), 32'd1);
      check($sformatf("hold%0d.phase", k), 32'(a_phase), 32'(k / 4));
      tick();
    end
    chk_a("hold.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    chk_a("hold.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    a_start = 1'b0;
    tick();
    check("hold.stay", 32'(a_busy), 32'd0);

    // Start and stop together in IDLE: stop wins
    a_start = 1'b1;
    a_stop  = 1'b1;
    tick();
    a_start = 1'b0;
    a_stop  = 1'b0;
    chk_a("both", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("both.stay", 32'(a_busy), 32'd0);

    // Asynchronous reset mid-cycle at busy cycle 10
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("arst.pre_busy", 32'(a_busy), 32'd1);
    check("arst.pre_phase", 32'(a_phase), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    chk_a("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk_a("arst.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst.no_restart", 32'(a_busy), 32'd0);
      check("arst.no_done", 32'(a_done), 32'd0);
    end

    // 1x1 mesh: single phase of a single step
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("c.busy", 32'(c_busy), 32'd1);
    check("c.row", 32'(c_row), 32'd1);
    check("c.odd", 32'(c_odd), 32'd0);
    check("c.sten", 32'(c_sten), 32'd1);
    check("c.phase", 32'(c_phase), 32'd0);
    check("c.done_run", 32'(c_done), 32'd0);
    tick();
    check("c.done", 32'(c_done), 32'd1);
    check("c.busy_end", 32'(c_busy), 32'd0);
    tick();
    check("c.done_clr", 32'(c_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
